sync_edge_filter: RTL and testbench
===================================

Name: sync_edge_filter

Overview:
- Sits directly downstream of ff_sync in the destination domain (clk_b).
- Takes the synchronized level (ff_sync sig_b[1]) and rejects short glitches, accepting only levels stable for STABLE_CYCLES samples.
- Emits single-cycle rise/fall pulses on each accepted transition and keeps a saturating count of accepted edges for status and debug.

Parameters:
- STABLE_CYCLES, 3: consecutive clk_b samples of a new level before it is accepted; legal range 1..255.
- CNT_W, 8: width of edge_cnt and glitch_cnt; legal range 2..32.

Ports:
- clk_b  input  1  destination-domain clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  synchronized level from ff_sync sig_b[1]; already in clk_b domain, no further synchronization.
- clr_cnt  input  1  synchronous clear of edge_cnt and glitch_cnt.
- sig_filt  output  1  filtered level, registered.
- rise_pulse  output  1  one-cycle pulse when an accepted 0->1 transition occurs.
- fall_pulse  output  1  one-cycle pulse when an accepted 1->0 transition occurs.
- edge_cnt  output  CNT_W  saturating count of accepted transitions, both directions.
- glitch_cnt  output  CNT_W  saturating count of rejected transitions; see Optional Feature.

Behaviour:
- Reset (async, rst=1):
  - Outputs immediately: sig_filt=0, rise_pulse=0, fall_pulse=0, edge_cnt=0, glitch_cnt=0.
  - Internal: state=STABLE, stab_cnt=0.
  - Takes effect without a clock edge, including mid-PEND.
- State machine, 2 states:
  - STABLE:
    - sig_in==sig_filt: stay; stab_cnt=0.
    - sig_in!=sig_filt: stab_cnt=1. If STABLE_CYCLES==1, accept on this same edge; else go to PEND.
  - PEND:
    - sig_in==sig_filt: reject. Return to STABLE, stab_cnt=0, glitch event.
    - sig_in!=sig_filt and stab_cnt+1==STABLE_CYCLES: accept. Return to STABLE.
    - Otherwise: stab_cnt+=1.
- Accept, all on the same edge:
  - sig_filt<=sig_in.
  - rise_pulse<=sig_in or fall_pulse<=~sig_in, high for exactly one cycle.
  - edge_cnt+=1.
- Latency:
  - sig_in first sampled different at edge k -> sig_filt and pulse change at edge k+STABLE_CYCLES-1.
  - With STABLE_CYCLES=1 the filter is a plain registered edge detector, latency 1 edge.
- Pulses:
  - Never both high.
  - Back-to-back accepts are impossible for STABLE_CYCLES>1; pulses separated by at least STABLE_CYCLES cycles.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt=1 clears both counters at the next edge and takes priority over a coincident increment (result 0).
  - The pulse and sig_filt update still occur on that edge.
- stab_cnt width 8 bits; cannot overflow given the legal STABLE_CYCLES range.
- sig_in is only ever sampled on clk_b; no combinational path from sig_in to any output.

Optional Feature:
- Macro: SYNC_EDGE_FILTER_GLITCH_CNT_EN.
- Defined: glitch_cnt increments, saturating, on every PEND->STABLE rejection; cleared by clr_cnt and rst.
- Undefined: glitch_cnt port is still present but tied to constant 0, and no counter register is built.
- edge_cnt behaviour is identical in both builds.

Test Plan (STABLE_CYCLES=3, CNT_W=8, clk_b period 20 ns, macro defined unless stated):
- Reset hold: rst=1 for 25 ns with sig_in=1, then release with sig_in held at 1.
  - During reset all outputs are 0.
  - sig_filt=1 and rise_pulse high one cycle at the 3rd rising edge after release; edge_cnt=1.
- Glitch reject: from a stable 0, sig_in=1 for 2 edges, then 0.
  - sig_filt stays 0; no pulse; edge_cnt unchanged.
  - glitch_cnt=1; glitch_cnt=0 in a build without the macro.
- Fall accept: from stable 1, sig_in=0 held.
  - fall_pulse for one cycle at the 3rd sampling edge; sig_filt=0; edge_cnt increments by 1.
- Saturation: CNT_W=2, 5 accepted transitions.
  - edge_cnt reads 1, 2, 3, 3, 3.
- Clear priority: clr_cnt=1 on the same edge as an accept.
  - edge_cnt=0 afterwards; rise_pulse still asserted and sig_filt updated.
- Async reset mid-PEND: assert rst 5 ns after the 2nd differing sample.
  - Outputs go to 0 without a clock edge.
  - After release with sig_in=1, a full 3 new samples are required before sig_filt=1.

Source files
------------

// File: rtl/sync_edge_filter.sv
// sync_edge_filter: debounce a synchronized level, pulse on accepted edges, count edges (glitch counter under SYNC_EDGE_FILTER_GLITCH_CNT_EN)
module sync_edge_filter #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr_cnt,
    output logic             sig_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] glitch_cnt
);
    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_PEND   = 1'b1;
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
    logic [0:0] state;
    logic [7:0] stab_cnt;
    logic       diff;
    logic       accept;
    // a new level is accepted once it has been seen STABLE_CYCLES edges in a row
    always_comb begin
        diff   = sig_in ^ sig_filt;
        accept = diff && (state == ST_PEND ? stab_cnt == STAB_LAST : STABLE_CYCLES == 1);
    end
    // track how long the differing level has persisted
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            state    <= ST_STABLE;
            stab_cnt <= 8'd0;
        end else begin
            state    <= (diff && !accept) ? ST_PEND : ST_STABLE;
            stab_cnt <= (diff && !accept) ? stab_cnt + 8'd1 : 8'd0;
        end
    end
    // filtered level and one-cycle edge pulses
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            sig_filt   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sig_filt   <= accept ? sig_in : sig_filt;
            rise_pulse <= accept && sig_in;
            fall_pulse <= accept && !sig_in;
        end
    end
    // saturating accepted-edge counter; clear wins over a coincident increment
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst)
            edge_cnt <= '0;
        else
            edge_cnt <= clr_cnt ? '0 : (accept && edge_cnt != '1) ? edge_cnt + CNT_W'(1) : edge_cnt;
    end
`ifdef SYNC_EDGE_FILTER_GLITCH_CNT_EN
    logic reject;
    assign reject = state == ST_PEND && !diff;
    // saturating count of pending levels that fell back before acceptance
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst)
            glitch_cnt <= '0;
        else
            glitch_cnt <= clr_cnt ? '0 : (reject && glitch_cnt != '1) ? glitch_cnt + CNT_W'(1) : glitch_cnt;
    end
`else
    assign glitch_cnt = '0;
`endif
endmodule

// File: tb/tb_sync_edge_filter.sv
// tb_sync_edge_filter: directed stimulus with a pulse scoreboard for sync_edge_filter
module tb_sync_edge_filter;
    logic       clk_b = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       sig2 = 1'b0;
    logic       sig_filt, rise_pulse, fall_pulse;
    logic [7:0] edge_cnt, glitch_cnt;
    logic       f2, r2, fa2;
    logic [1:0] ec2, gc2;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         mon_err = 0;
    int         mon_chk = 0;
`ifdef SYNC_EDGE_FILTER_GLITCH_CNT_EN
    localparam int G_ON = 1;
`else
    localparam int G_ON = 0;
`endif
    typedef struct {
        logic       rise;
        logic [7:0] cnt;
        int         at;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [1:0] sat_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    sync_edge_filter #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
        .clk_b(clk_b), .rst(rst), .sig_in(sig_in), .clr_cnt(clr_cnt),
        .sig_filt(sig_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_cnt(edge_cnt), .glitch_cnt(glitch_cnt)
    );

    sync_edge_filter #(.STABLE_CYCLES(3), .CNT_W(2)) dut2 (
        .clk_b(clk_b), .rst(rst), .sig_in(sig2), .clr_cnt(1'b0),
        .sig_filt(f2), .rise_pulse(r2), .fall_pulse(fa2),
        .edge_cnt(ec2), .glitch_cnt(gc2)
    );

    always #10 clk_b = ~clk_b;

    always @(posedge clk_b) cyc <= cyc + 1;

    always @(negedge clk_b) begin
        if (sb.size() > 0 && sb[0].at < cyc) begin
            mon_chk++;
            mon_err++;
            $display("FAIL missed_pulse: no pulse at cycle %0d (now %0d)", sb[0].at, cyc);
            void'(sb.pop_front());
        end
        if (rise_pulse || fall_pulse) begin
            mon_chk++;
            if (sb.size() == 0) begin
                mon_err++;
                $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, required none", rise_pulse, fall_pulse, cyc);
            end else begin
                e = sb.pop_front();
                if (e.at != cyc || rise_pulse != e.rise || fall_pulse == e.rise || sig_filt != e.rise
                    || edge_cnt != e.cnt || glitch_cnt != 8'd0) begin
                    mon_err++;
                    $display("FAIL pulse: got cyc=%0d rise=%b fall=%b filt=%b edge=%0d glitch=%0d, required cyc=%0d rise=%b fall=%b filt=%b edge=%0d glitch=0",
                             cyc, rise_pulse, fall_pulse, sig_filt, edge_cnt, glitch_cnt,
                             e.at, e.rise, !e.rise, e.rise, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_b);
        #1;
    endtask

    initial begin
        #5;
        chk("rst_filt", 32'(sig_filt), 0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 0);
        chk("rst_edge", 32'(edge_cnt), 0);
        chk("rst_glitch", 32'(glitch_cnt), 0);
        #10;
        chk("rst_filt_clocked", 32'(sig_filt), 0);
        #10;
        sb.push_back('{1'b1, 8'd1, cyc + 3});
        rst = 1'b0;
        step(4);
        chk("release_filt", 32'(sig_filt), 1);
        chk("release_edge", 32'(edge_cnt), 1);
        sig_in = 1'b0;
        sb.push_back('{1'b0, 8'd2, cyc + 3});
        step(4);
        chk("fall_filt", 32'(sig_filt), 0);
        chk("fall_edge", 32'(edge_cnt), 2);
        sig_in = 1'b1;
        step(2);
        sig_in = 1'b0;
        step(3);
        chk("glitch2_filt", 32'(sig_filt), 0);
        chk("glitch2_edge", 32'(edge_cnt), 2);
        chk("glitch2_cnt", 32'(glitch_cnt), 32'(G_ON));
        sig_in = 1'b1;
        step(1);
        sig_in = 1'b0;
        step(3);
        chk("glitch1_cnt", 32'(glitch_cnt), 32'(2 * G_ON));
        chk("glitch1_filt", 32'(sig_filt), 0);
        sig_in = 1'b1;
        sb.push_back('{1'b1, 8'd0, cyc + 3});
        step(2);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("clr_rise", 32'(rise_pulse), 1);
        chk("clr_filt", 32'(sig_filt), 1);
        chk("clr_edge", 32'(edge_cnt), 0);
        chk("clr_glitch", 32'(glitch_cnt), 0);
        step(2);
        chk("clr_edge_hold", 32'(edge_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            sig2 = ~sig2;
            step(4);
            chk($sformatf("sat_edge%0d", i), 32'(ec2), 32'(sat_tbl[i]));
        end
        sig_in = 1'b0;
        step(2);
        #4;
        rst = 1'b1;
        #1;
        chk("async_filt", 32'(sig_filt), 0);
        chk("async_edge", 32'(edge_cnt), 0);
        chk("async_pulses", 32'({rise_pulse, fall_pulse}), 0);
        sig_in = 1'b1;
        #2;
        rst = 1'b0;
        sb.push_back('{1'b1, 8'd1, cyc + 3});
        step(2);
        chk("async_still_low", 32'(sig_filt), 0);
        step(2);
        chk("async_filt_high", 32'(sig_filt), 1);
        chk("async_edge_one", 32'(edge_cnt), 1);
        step(2);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        errors += mon_err;
        checks += mon_chk;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
